uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single UART TX byte channel between N_REQ requesters (e.g. CPU register port, DMA, loopback/test source).
- Grants one requester at a time and holds the grant for a whole message, delimited by `last`.
- Fairness cap: a grant is forcibly released after MAX_BURST bytes.
- Drives the TX-side request-to-send toward the flow-control block and gates byte handshakes with the returned clear-to-send.
- Sits between the requesters and the UART TX serializer / flow-control pair.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 8, byte width
- MAX_BURST, 16, max bytes per grant before forced release (≥1)
- ID_W, $clog2(N_REQ), width of grant index

Ports:
- tck  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  N_REQ  per-requester byte valid
- req_data_i  in  N_REQ*DATA_W  per-requester byte; requester k uses slice [k*DATA_W +: DATA_W]
- req_last_i  in  N_REQ  marks final byte of the requester's message
- req_ready_o  out  N_REQ  per-requester byte accepted
- tx_valid_o  out  1  byte valid to TX serializer
- tx_data_o  out  DATA_W  byte to TX serializer
- tx_ready_i  in  1  TX serializer can take a byte
- tx_rts_n_o  out  1  active-low request to send, to flow control
- tx_cts_n_i  in  1  active-low clear to send, from flow control
- tx_enable_i  in  1  TX path enabled by mode logic
- grant_id_o  out  ID_W  index of current owner
- busy_o  out  1  a grant is active
- preempt_o  out  1  one-cycle pulse when MAX_BURST forced a release

Behaviour:
- Reset, asynchronous: state ARB_IDLE, rr_ptr=0, beat_cnt=0. Outputs: req_ready_o=0, tx_valid_o=0, tx_data_o=0, tx_rts_n_o=1, grant_id_o=0, busy_o=0, preempt_o=0. Reset mid-burst abandons the burst with no further handshakes.
- Byte transfer ("beat"): occurs in a cycle with state==ARB_GRANT, tx_valid_o=1, tx_ready_i=1, tx_cts_n_i=0.
- ARB_IDLE:
  - If tx_enable_i=1 and any req_valid_i is set: select the first valid index searching circularly from rr_ptr.
  - Register it as grant_id_o and go to ARB_GRANT next cycle, so grant latency is 1 cycle.
  - No handshakes occur in ARB_IDLE.
- ARB_GRANT:
  - busy_o=1 and tx_rts_n_o=0.
  - tx_valid_o = req_valid_i[g] & ~tx_cts_n_i.
  - tx_data_o = data slice of g; combinational pass-through, zero added latency.
  - req_ready_o[g] = tx_ready_i & ~tx_cts_n_i; all other ready bits are 0.
  - beat_cnt increments on each beat.
  - On a beat with req_last_i[g]=1: go to ARB_GAP, rr_ptr=(g+1) mod N_REQ, beat_cnt=0.
  - On a beat where beat_cnt==MAX_BURST-1 and last=0: same transition, plus preempt_o=1 in the following cycle.
  - Last and cap on the same beat: treated as last; no preempt.
  - Requester drops valid mid-message: grant is held, no timeout.
  - tx_enable_i=0 while in ARB_GRANT: the grant is held, but tx_valid_o and req_ready_o are forced to 0.
- ARB_GAP:
  - One turnaround cycle with tx_rts_n_o=1, so flow control returns to idle between owners.
  - Next state ARB_IDLE.
- tx_data_o holds its last value outside ARB_GRANT; it is don't-care when tx_valid_o=0 but must not be X after reset.
- N_REQ not a power of two: rr_ptr wraps at N_REQ, never at 2^ID_W.

Decomposition:
- uart_defs package additions:
  - ArbState_t enum {ARB_IDLE, ARB_GRANT, ARB_GAP}
  - UART_DATA_W=8 constant
- Sub-module rr_picker: purely combinational. Inputs req vector and ptr; outputs found and idx. Reusable by the RX-side fan-out later.

Test Plan:
- Single requester 2, 3-byte message {0xA1,0xA2,0xA3(last)}, tx_ready_i=1, cts_n=0 -> grant_id_o=2 one cycle after valid; 3 consecutive beats; ARB_GAP shows tx_rts_n_o=1 for 1 cycle; rr_ptr=3.
- All 4 requesters valid, each sending a 1-byte message, rr_ptr=0 -> service order 0,1,2,3,0; each grant separated by IDLE+GAP.
- Requester 1 streams 20 bytes, no last, MAX_BURST=16 -> 16 beats, then preempt_o pulses once; requester 2, also valid, is granted next; requester 1 resumes with byte 17 later.
- cts_n_i=1 for 5 cycles mid-message -> tx_valid_o=0 and req_ready_o=0 during stall; no bytes lost or duplicated; data order preserved.
- Byte 16 carries last=1 with MAX_BURST=16 -> normal release, preempt_o stays 0.
- Assert rst_n low during beat 2 of 4 -> all outputs at reset values immediately; after release, arbitration restarts from rr_ptr=0.

Source files
------------

// File: rtl/uart_defs_pkg.sv
// rtl/uart_defs_pkg.sv - shared UART types and constants
package uart_defs;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_GAP
  } ArbState_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin search: first set bit of req at or after ptr
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             found,
  output logic [ID_W-1:0]  idx
);

  int              j;
  logic [ID_W-1:0] jj;

  // Walk offsets from farthest to nearest so the nearest hit to ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    jj    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      jj = ID_W'(j);
      if (req[jj]) begin
        found = 1'b1;
        idx   = jj;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin owner of the UART TX byte channel, message-granular with burst cap
module uart_tx_arbiter
  import uart_defs::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = UART_DATA_W,
  parameter int MAX_BURST = 16,
  parameter int ID_W      = $clog2(N_REQ)
) (
  input  logic                    tck,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  input  logic [N_REQ-1:0]        req_last_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic                    tx_valid_o,
  output logic [DATA_W-1:0]       tx_data_o,
  input  logic                    tx_ready_i,
  output logic                    tx_rts_n_o,
  input  logic                    tx_cts_n_i,
  input  logic                    tx_enable_i,
  output logic [ID_W-1:0]         grant_id_o,
  output logic                    busy_o,
  output logic                    preempt_o
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CAP_LAST = CNT_W'(MAX_BURST - 1);

  ArbState_t         state;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  beat_cnt;
  logic [DATA_W-1:0] data_hold;

  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic              in_grant;
  logic              hs_ok;
  logic              g_valid;
  logic              g_last;
  logic [DATA_W-1:0] g_data;
  logic              beat;
  logic              at_cap;
  logic [ID_W-1:0]   next_ptr;

  rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req   (req_valid_i),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign in_grant = (state == ARB_GRANT);
  assign hs_ok    = in_grant & tx_enable_i & ~tx_cts_n_i;
  assign g_valid  = req_valid_i[grant_id_o];
  assign g_last   = req_last_i[grant_id_o];
  assign g_data   = req_data_i[grant_id_o*DATA_W +: DATA_W];
  assign at_cap   = (beat_cnt == CAP_LAST);
  assign next_ptr = (grant_id_o == ID_W'(N_REQ - 1)) ? '0 : grant_id_o + 1'b1;

  assign tx_valid_o = hs_ok & g_valid;
  assign beat       = tx_valid_o & tx_ready_i;
  // Data is passed straight through while granted; otherwise the last granted byte is held.
  assign tx_data_o  = in_grant ? g_data : data_hold;

  always_comb begin
    req_ready_o = '0;
    if (hs_ok && tx_ready_i) req_ready_o[grant_id_o] = 1'b1;
  end

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      grant_id_o <= '0;
      busy_o     <= 1'b0;
      tx_rts_n_o <= 1'b1;
      preempt_o  <= 1'b0;
      data_hold  <= '0;
    end else begin
      preempt_o <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (tx_enable_i && pick_found) begin
            grant_id_o <= pick_idx;
            state      <= ARB_GRANT;
            busy_o     <= 1'b1;
            tx_rts_n_o <= 1'b0;
          end
        end
        ARB_GRANT: begin
          data_hold <= g_data;
          if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
            // A message end wins over the cap, so a last byte at the cap is not a preemption.
            if (g_last || at_cap) begin
              state      <= ARB_GAP;
              rr_ptr     <= next_ptr;
              beat_cnt   <= '0;
              busy_o     <= 1'b0;
              tx_rts_n_o <= 1'b1;
              preempt_o  <= ~g_last;
            end
          end
        end
        ARB_GAP: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule
